wide_add_sequencer: RTL and testbench
=====================================

# wide_add_sequencer

Multi-cycle, multi-precision add/subtract controller. It accepts two operands of NUM_CHUNKS×DATA_WIDTH bits and computes the result through one shared DATA_WIDTH-bit ripple-carry chunk adder, one chunk per cycle, least-significant chunk first. It sits between an operand producer and a result consumer, both using valid/ready handshakes. It lets wide arithmetic reuse a single narrow ripple adder instead of a full-width carry chain.

## Interface
- DATA_WIDTH, 8, width of one chunk and of the shared adder
- NUM_CHUNKS, 4, number of chunks per operand (≥1); W = DATA_WIDTH*NUM_CHUNKS
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset, sampled on rising clk
- din_a  in  W  operand A
- din_b  in  W  operand B
- din_sub  in  1  0 = A+B, 1 = A−B (two's complement)
- din_valid  in  1  operand request
- din_ready  out  1  block can accept operands
- dout  out  W+1  result; bit W = final carry-out (for sub: 1 = no borrow)
- dout_valid  out  1  result available
- dout_ready  in  1  consumer accepts result
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: din_ready=1. On din_valid&din_ready:
  - latch A into a_reg.
  - latch B into b_reg; B is inverted before latching when din_sub=1.
  - set carry_reg = din_sub.
  - clear chunk_idx to 0.
  - clear the result register.
  - go to RUN.
- RUN: each cycle, the chunk adder adds a_reg chunk[chunk_idx] + b_reg chunk[chunk_idx] + carry_reg.
  - The DATA_WIDTH sum is written to result chunk[chunk_idx].
  - carry_reg takes the chunk carry-out.
  - chunk_idx increments.
  - When chunk_idx = NUM_CHUNKS−1, go to DONE after this cycle and write the final carry into result bit W.
- DONE: dout_valid=1, and dout holds the result.
  - On dout_ready, go to IDLE.
  - There is no same-cycle accept of new operands in DONE.
- din_ready is high only in IDLE. din_* are ignored in RUN and DONE.
- Arithmetic width rules:
  - The sum is exact, W+1 bits.
  - Subtraction result bits [W-1:0] are (A−B) mod 2^W.
  - Bit W = 1 iff A ≥ B (unsigned).
- chunk_idx width is $clog2(NUM_CHUNKS), minimum 1. It never wraps past NUM_CHUNKS−1.
- When NUM_CHUNKS = 1, RUN lasts exactly one cycle.

## Timing
- Reset values:
  - state=IDLE, din_ready=1, dout_valid=0, busy=0, dout=0.
  - carry_reg=0, chunk_idx=0.
- Reset applied in any state, including mid-RUN or DONE with dout_valid high: at the next edge, all outputs return to reset values and the in-flight operation is discarded. No partial result is emitted.
- Latency: acceptance at edge E0 → dout_valid high after edge E(NUM_CHUNKS). That is NUM_CHUNKS cycles after acceptance.
- Throughput: one operation per NUM_CHUNKS+2 cycles under no backpressure, since DONE→IDLE→accept each take one cycle.
- dout and dout_valid are registered outputs. They are stable while dout_valid=1 and dout_ready=0, for any duration.
- din_ready and busy are registered/state-decoded, with no combinational path from din_valid or dout_ready.
- The critical path is one DATA_WIDTH ripple chain plus the chunk mux.

## Structure
- The shared package holds:
  - the state enum typedef (IDLE, RUN, DONE).
  - the default DATA_WIDTH and NUM_CHUNKS constants.
- Sub-module chunk_adder: combinational DATA_WIDTH-bit ripple-carry adder built from full-adder cells.
  - ports: a, b, cin, sum, cout.
  - Exactly one instance.
- The controller holds the FSM, the operand/result registers, the chunk mux and the write-enable decode.

## Test plan
- DATA_WIDTH=8, NUM_CHUNKS=4, A=0xFFFFFFFF, B=0x00000001, add:
  - dout=0x1_00000000.
  - dout_valid rises exactly 4 cycles after acceptance.
  - carry propagates through all chunks.
- Sub A=5, B=3 → dout=0x1_00000002. Sub A=3, B=5 → dout=0x0_FFFFFFFE.
- Backpressure: hold dout_ready=0 for 6 cycles after a result.
  - dout and dout_valid stay constant, and din_ready=0 throughout.
  - dout_ready=1 → IDLE next cycle, with din_ready=1.
- Assert reset during the 2nd RUN cycle of 0x12345678+0x11111111:
  - next cycle all outputs are at reset values.
  - no dout_valid pulse follows.
  - a fresh 0x00000010+0x00000020 returns 0x0_00000030.
- Back-to-back stream of 20 random add/sub ops with din_valid held high and random dout_ready:
  - results match a reference model in order.
  - spacing is ≥ NUM_CHUNKS+2 cycles.
  - din_* changes during RUN are ignored.
- NUM_CHUNKS=1, DATA_WIDTH=8: 0xFF+0xFF → dout=0x1FE, one cycle after acceptance.

Source files
------------

// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and default sizing for the multi-precision add/subtract sequencer.
package wide_add_sequencer_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefNumChunks = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/wide_add_sequencer_chunk_adder.sv
// Combinational ripple-carry adder for one chunk, built from full-adder cells.
module wide_add_sequencer_chunk_adder
    import wide_add_sequencer_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth
) (
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic                 cin,
    output logic [DataWidth-1:0] sum,
    output logic                 cout
);

    logic [DataWidth:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DataWidth; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[DataWidth];

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract controller: one shared chunk adder, one chunk per cycle, LSB chunk first.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned NUM_CHUNKS = DefNumChunks
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH*NUM_CHUNKS-1:0] din_a,
    input  logic [DATA_WIDTH*NUM_CHUNKS-1:0] din_b,
    input  logic                             din_sub,
    input  logic                             din_valid,
    output logic                             din_ready,
    output logic [DATA_WIDTH*NUM_CHUNKS:0]   dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic                             busy
);

    localparam int unsigned W    = DATA_WIDTH * NUM_CHUNKS;
    localparam int unsigned IdxW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHUNKS - 1);

    state_e                state_q;
    logic [W-1:0]          a_q, b_q;
    logic                  carry_q;
    logic [IdxW-1:0]       idx_q;
    logic [W:0]            result_q, result_d;
    logic                  din_ready_q, dout_valid_q, busy_q;
    logic [DATA_WIDTH-1:0] a_chunk, b_chunk, sum;
    logic                  cout;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_chunk = a_q[i*DATA_WIDTH +: DATA_WIDTH];
                b_chunk = b_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    wide_add_sequencer_chunk_adder #(
        .DataWidth(DATA_WIDTH)
    ) u_chunk_adder (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry_q),
        .sum (sum),
        .cout(cout)
    );

    // Write-enable decode: only the current chunk slot (and the carry bit on the last chunk).
    always_comb begin
        result_d = result_q;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (idx_q == IdxW'(i)) begin
                result_d[i*DATA_WIDTH +: DATA_WIDTH] = sum;
            end
        end
        if (idx_q == LastIdx) begin
            result_d[W] = cout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            result_q     <= '0;
            din_ready_q  <= 1'b1;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (din_valid) begin
                        a_q         <= din_a;
                        b_q         <= din_sub ? ~din_b : din_b;
                        carry_q     <= din_sub;
                        idx_q       <= '0;
                        result_q    <= '0;
                        state_q     <= StRun;
                        din_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                StRun: begin
                    result_q <= result_d;
                    carry_q  <= cout;
                    if (idx_q == LastIdx) begin
                        state_q      <= StDone;
                        dout_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (dout_ready) begin
                        state_q      <= StIdle;
                        dout_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        din_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign din_ready  = din_ready_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign dout       = result_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomized self-checking bench for wide_add_sequencer (4-chunk and 1-chunk instances).
module tb_wide_add_sequencer;

    localparam int unsigned NC = 4;
    localparam int unsigned W  = 8 * NC;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din_a, din_b;
    logic         din_sub, din_valid, din_ready;
    logic [W:0]   dout;
    logic         dout_valid, dout_ready, busy;

    logic [7:0]   s_a, s_b;
    logic         s_sub, s_valid, s_ready;
    logic [8:0]   s_dout;
    logic         s_dvalid, s_dready, s_busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(
        .DATA_WIDTH(8),
        .NUM_CHUNKS(NC)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .din_a     (din_a),
        .din_b     (din_b),
        .din_sub   (din_sub),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy      (busy)
    );

    wide_add_sequencer #(
        .DATA_WIDTH(8),
        .NUM_CHUNKS(1)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .din_a     (s_a),
        .din_b     (s_b),
        .din_sub   (s_sub),
        .din_valid (s_valid),
        .din_ready (s_ready),
        .dout      (s_dout),
        .dout_valid(s_dvalid),
        .dout_ready(s_dready),
        .busy      (s_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Exact unsigned arithmetic: sum with carry, or difference with "no borrow" flag.
    function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub);
        logic [W-1:0] diff;
        if (sub) begin
            diff = a - b;
            return {(a >= b), diff};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Accept at one edge, scramble din_* while running, then count edges until dout_valid.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output int cyc);
        din_a = a; din_b = b; din_sub = sub; din_valid = 1'b1;
        tick();
        cyc = 0;
        while (!dout_valid && cyc < 20) begin
            din_a = $urandom; din_b = $urandom; din_sub = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        din_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input int hold);
        logic [W:0] exp;
        int         cyc;
        exp = ref_model(a, b, sub);
        launch(a, b, sub, cyc);
        check({tag, " latency"}, 64'(cyc), 64'(NC));
        check({tag, " dout"}, 64'(dout), 64'(exp));
        check({tag, " busy"}, 64'(busy), 64'd1);
        for (int i = 0; i < hold; i++) begin
            din_valid = 1'b1; din_a = $urandom; din_b = $urandom;
            tick();
            check({tag, " hold dout"}, 64'(dout), 64'(exp));
            check({tag, " hold valid"}, 64'(dout_valid), 64'd1);
            check({tag, " hold din_ready"}, 64'(din_ready), 64'd0);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check({tag, " idle din_ready"}, 64'(din_ready), 64'd1);
        check({tag, " idle dout_valid"}, 64'(dout_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         cyc, cycle, accepted, consumed, last_acc;
        logic       seen;
        logic [W:0] q[$];

        reset = 1'b1;
        din_a = '0; din_b = '0; din_sub = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        s_a = '0; s_b = '0; s_sub = 1'b0; s_valid = 1'b0; s_dready = 1'b0;
        repeat (2) tick();
        check("rst din_ready", 64'(din_ready), 64'd1);
        check("rst dout_valid", 64'(dout_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst dout", 64'(dout), 64'd0);
        reset = 1'b0;
        tick();

        do_op("carry chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op("sub 5-3", 32'd5, 32'd3, 1'b1, 0);
        do_op("sub 3-5", 32'd3, 32'd5, 1'b1, 6);
        for (int i = 0; i < 4; i++)
            do_op("rand op", $urandom, $urandom, 1'($urandom_range(0, 1)), 1);

        // Reset during the second RUN cycle discards the operation.
        din_a = 32'h1234_5678; din_b = 32'h1111_1111; din_sub = 1'b0; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrun rst din_ready", 64'(din_ready), 64'd1);
        check("midrun rst dout_valid", 64'(dout_valid), 64'd0);
        check("midrun rst busy", 64'(busy), 64'd0);
        check("midrun rst dout", 64'(dout), 64'd0);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (dout_valid) seen = 1'b1;
        end
        check("midrun no pulse", 64'(seen), 64'd0);
        do_op("fresh", 32'h0000_0010, 32'h0000_0020, 1'b0, 0);

        // Reset while a result is waiting in DONE.
        launch(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, cyc);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("done rst dout_valid", 64'(dout_valid), 64'd0);
        check("done rst dout", 64'(dout), 64'd0);
        tick();

        // Streaming: din_valid held high, random backpressure, scoreboard in order.
        cycle = 0; accepted = 0; consumed = 0; last_acc = -1;
        while (consumed < 20 && cycle < 3000) begin
            din_a = $urandom; din_b = $urandom; din_sub = 1'($urandom_range(0, 1));
            dout_ready = 1'($urandom_range(0, 1));
            din_valid  = (accepted < 20);
            if (din_ready && din_valid) begin
                q.push_back(ref_model(din_a, din_b, din_sub));
                if (last_acc >= 0)
                    check("stream spacing", 64'((cycle - last_acc) >= int'(NC + 2)), 64'd1);
                last_acc = cycle;
                accepted++;
            end
            if (dout_valid && dout_ready) begin
                if (q.size() == 0) check("stream unexpected result", 64'(dout), 64'h0);
                else check("stream dout", 64'(dout), 64'(q.pop_front()));
                consumed++;
            end
            tick();
            cycle++;
        end
        check("stream count", 64'(consumed), 64'd20);
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        tick();
        check("stream idle", 64'(din_ready), 64'd1);

        // Single-chunk instance: RUN lasts one cycle.
        s_a = 8'hFF; s_b = 8'hFF; s_sub = 1'b0; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        cyc = 0;
        while (!s_dvalid && cyc < 10) begin
            tick();
            cyc++;
        end
        check("nc1 latency", 64'(cyc), 64'd1);
        check("nc1 dout", 64'(s_dout), 64'h1FE);
        s_dready = 1'b1;
        tick();
        s_dready = 1'b0;
        check("nc1 idle", 64'(s_ready), 64'd1);
        s_a = 8'h10; s_b = 8'h20; s_sub = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        check("nc1 sub dout", 64'(s_dout), 64'h0F0);
        check("nc1 sub busy", 64'(s_busy), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
